// File: rtl/riscv_fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, fetches over a req/gnt/rvalid
// handshake, and presents one instruction at a time in the IF/ID register.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        pcSrc,
    input  logic [31:0] target_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   req_pc;
    logic              hold_valid;
    logic [XLEN-1:0]   hold_pc;
    logic [XLEN-1:0]   hold_instr;

    logic              fire;
    logic              resp_ok;
    logic              kill;
    logic              out_free;
    logic              unused_tgt_lsb;

    // Target low bits are forced to zero, so they are deliberately dropped.
    assign unused_tgt_lsb = ^target_pc[1:0];

    assign kill      = flush | pcSrc;
    assign out_free  = !if_valid || !stall;
    assign imem_addr = pc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, request and response-acceptance decode.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        fire      = 1'b0;
        resp_ok   = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = REQ;
            end
            REQ: begin
                // A full hold buffer blocks new fetches so it cannot overflow.
                imem_req = !hold_valid;
                if (!hold_valid && imem_gnt) begin
                    fire      = 1'b1;
                    state_nxt = pcSrc ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    resp_ok   = !pcSrc;
                    state_nxt = REQ;
                end else if (pcSrc) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // Program counter and address of the outstanding fetch; redirect wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            if (fire) begin
                req_pc <= pc;
            end
            if (pcSrc) begin
                pc <= {target_pc[XLEN-1:2], 2'b00};
            end else if (fire) begin
                pc <= pc + PC_STEP;
            end
        end
    end

    // IF/ID register and one-entry hold buffer for responses decode can't take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid   <= 1'b0;
            if_pc      <= '0;
            if_instr   <= NOP_INSTR;
            hold_valid <= 1'b0;
            hold_pc    <= '0;
            hold_instr <= '0;
        end else if (kill) begin
            if_valid   <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            if (out_free && hold_valid) begin
                if_valid <= 1'b1;
                if_pc    <= hold_pc;
                if_instr <= hold_instr;
            end else if (out_free && resp_ok) begin
                if_valid <= 1'b1;
                if_pc    <= req_pc;
                if_instr <= imem_rdata;
            end else if (out_free) begin
                if_valid <= 1'b0;
            end

            if (resp_ok && (!out_free || hold_valid)) begin
                hold_valid <= 1'b1;
                hold_pc    <= req_pc;
                hold_instr <= imem_rdata;
            end else if (out_free && hold_valid) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: directed vector table, directed
// corner sequences, and randomized traffic against a transaction-level model.
module tb_riscv_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        pcSrc = 1'b0;
    logic [31:0] target_pc = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    riscv_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .pcSrc(pcSrc),
        .target_pc(target_pc), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Memory: FIFO of granted addresses with cycles-until-response.
    logic [31:0] mq_addr[$];
    int          mq_cnt[$];
    int          fix_lat = 1;
    bit          rand_mode = 1'b0;
    logic        rst_drv = 1'b0;
    bit          fired = 1'b0;
    logic [31:0] fire_addr = '0;

    // Model: flags describing the fetch in flight rather than FSM states.
    logic [31:0] m_pc, m_req_pc, m_if_pc, m_if_instr;
    logic        m_v, m_busy, m_wrong, m_booted;
    logic [63:0] m_hold[$];

    typedef struct {
        logic        stall;
        logic        ex_req;
        logic [31:0] ex_addr;
        logic        ex_valid;
        logic [31:0] ex_pc;
        logic [31:0] ex_instr;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        checks++;
        $display("FAIL %s: timed out waiting for DUT event", name);
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_req_pc = '0; m_if_pc = '0; m_if_instr = NOP;
        m_v = 1'b0; m_busy = 1'b0; m_wrong = 1'b0; m_booted = 1'b0;
        m_hold.delete();
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic redirect, kill, req, fire, got, acc, free, had_hold;
        logic [63:0] ent, h;
        if (!rst_n) begin
            model_reset();
            return;
        end
        redirect = pcSrc;
        kill     = flush | pcSrc;
        req      = m_booted && !m_busy && (m_hold.size() == 0);
        fire     = req && imem_gnt;
        got      = m_busy && imem_rvalid;
        acc      = got && !m_wrong && !redirect;
        free     = !m_v || !stall;
        had_hold = (m_hold.size() != 0);
        ent      = {m_req_pc, imem_rdata};
        if (kill) begin
            m_v = 1'b0;
            m_hold.delete();
        end else begin
            if (free && had_hold) begin
                h = m_hold.pop_front();
                m_v = 1'b1; m_if_pc = h[63:32]; m_if_instr = h[31:0];
            end else if (free && acc) begin
                m_v = 1'b1; m_if_pc = ent[63:32]; m_if_instr = ent[31:0];
            end else if (free) begin
                m_v = 1'b0;
            end
            if (acc && !(free && !had_hold)) m_hold.push_back(ent);
        end
        if (fire) m_req_pc = m_pc;
        if (redirect) m_pc = {target_pc[31:2], 2'b00};
        else if (fire) m_pc = m_pc + 32'd4;
        if (fire) begin
            m_busy = 1'b1; m_wrong = redirect;
        end else if (got) begin
            m_busy = 1'b0; m_wrong = 1'b0;
        end else if (m_busy && redirect) begin
            m_wrong = 1'b1;
        end
        m_booted = 1'b1;
    endtask

    task automatic compare_model();
        chk("req",   32'(imem_req), 32'(m_booted && !m_busy && (m_hold.size() == 0)));
        chk("addr",  imem_addr, m_pc);
        chk("valid", 32'(if_valid), 32'(m_v));
        chk("if_pc", if_pc, m_if_pc);
        chk("instr", if_instr, m_if_instr);
    endtask

    // Drive one cycle's inputs at the falling edge, then step model and memory just before the rise.
    task automatic tick(input logic s, input logic f, input logic p, input logic [31:0] t);
        int lat;
        rst_n = rst_drv; stall = s; flush = f; pcSrc = p; target_pc = t;
        imem_gnt = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mq_cnt.size() > 0 && mq_cnt[0] <= 0) begin
            imem_rvalid = 1'b1; imem_rdata = mq_addr[0] + 32'h100;
        end else begin
            imem_rvalid = 1'b0; imem_rdata = $urandom;
        end
        #4;
        model_step();
        fired = imem_req && imem_gnt;
        fire_addr = imem_addr;
        if (imem_rvalid) begin
            void'(mq_addr.pop_front());
            void'(mq_cnt.pop_front());
        end
        foreach (mq_cnt[i]) mq_cnt[i] = mq_cnt[i] - 1;
        if (fired) begin
            lat = rand_mode ? int'($urandom_range(1, 4)) : fix_lat;
            mq_addr.push_back(imem_addr);
            mq_cnt.push_back(lat - 1);
        end
    endtask

    task automatic cyc(input logic s, input logic f, input logic p, input logic [31:0] t);
        @(negedge clk);
        compare_model();
        tick(s, f, p, t);
    endtask

    task automatic do_reset();
        rst_drv = 1'b0;
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        rst_drv = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        logic [31:0] a;
        logic s, f, p;
        logic [31:0] t;

        // stall, req, addr, valid, if_pc, if_instr  (single-cycle memory, data = addr+0x100)
        tbl[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00, NOP};
        tbl[1]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00, NOP};
        tbl[2]  = '{1'b0, 1'b0, 32'h04, 1'b0, 32'h00, NOP};
        tbl[3]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00, 32'h100};
        tbl[4]  = '{1'b0, 1'b0, 32'h08, 1'b0, 32'h00, 32'h100};
        tbl[5]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04, 32'h104};
        tbl[6]  = '{1'b0, 1'b0, 32'h0C, 1'b0, 32'h04, 32'h104};
        tbl[7]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08, 32'h108};
        tbl[8]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08, 32'h108};
        tbl[9]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08, 32'h108};
        tbl[10] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08, 32'h108};
        tbl[11] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08, 32'h108};
        tbl[12] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h08, 32'h108};
        tbl[13] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C, 32'h10C};
        tbl[14] = '{1'b0, 1'b0, 32'h14, 1'b0, 32'h0C, 32'h10C};
        tbl[15] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h10, 32'h110};

        model_reset();
        #1 rst_n = 1'b0;

        // Vector table: reset values, in-order fetch, stall into hold buffer.
        rand_mode = 1'b0; fix_lat = 1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_req", i),   32'(imem_req), 32'(tbl[i].ex_req));
            chk($sformatf("tbl%0d_addr", i),  imem_addr, tbl[i].ex_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(tbl[i].ex_valid));
            chk($sformatf("tbl%0d_pc", i),    if_pc, tbl[i].ex_pc);
            chk($sformatf("tbl%0d_instr", i), if_instr, tbl[i].ex_instr);
            tick(tbl[i].stall, 1'b0, 1'b0, 32'h0);
        end

        // Redirect+flush one cycle after the grant for 0x8, slow memory.
        fix_lat = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            if (fired && fire_addr == 32'h8) found = 1'b1;
        end
        if (!found) timeout("seqA_fire8");
        cyc(1'b1, 1'b1, 1'b1, 32'h40);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            compare_model();
            if (imem_req) begin
                found = 1'b1;
                chk("seqA_redir_addr", imem_addr, 32'h40);
                chk("seqA_valid", 32'(if_valid), 32'h0);
            end
            tick(1'b0, 1'b0, 1'b0, 32'h0);
        end
        if (!found) timeout("seqA_req40");
        repeat (12) cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect coinciding with rvalid in WAIT, misaligned target.
        fix_lat = 1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            if (fired && fire_addr == 32'h8) found = 1'b1;
        end
        if (!found) timeout("seqB_fire8");
        cyc(1'b0, 1'b0, 1'b1, 32'h83);
        @(negedge clk);
        compare_model();
        chk("seqB_addr", imem_addr, 32'h80);
        chk("seqB_req", 32'(imem_req), 32'h1);
        chk("seqB_valid", 32'(if_valid), 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (8) cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Flush without redirect while stalled.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            compare_model();
            if (if_valid) found = 1'b1;
            else tick(1'b0, 1'b0, 1'b0, 32'h0);
        end
        if (!found) timeout("seqC_valid");
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        compare_model();
        a = imem_addr;
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        compare_model();
        chk("seqC_flush_valid", 32'(if_valid), 32'h0);
        chk("seqC_pc_kept", imem_addr, fired ? a + 32'd4 : a);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (12) cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset pulse during WAIT; stale response arrives after release.
        fix_lat = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            if (fired && fire_addr == 32'h4) found = 1'b1;
        end
        if (!found) timeout("seqD_fire4");
        rst_drv = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("seqD_rst_req", 32'(imem_req), 32'h0);
        chk("seqD_rst_addr", imem_addr, RST_PC);
        chk("seqD_rst_valid", 32'(if_valid), 32'h0);
        chk("seqD_rst_pc", if_pc, 32'h0);
        chk("seqD_rst_instr", if_instr, NOP);
        rst_drv = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        compare_model();
        chk("seqD_restart_addr", imem_addr, RST_PC);
        chk("seqD_restart_req", 32'(imem_req), 32'h1);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (12) cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // PC wrap-around at the top of the address space.
        fix_lat = 1;
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            if (fired && fire_addr == 32'hFFFF_FFFC) found = 1'b1;
        end
        if (!found) timeout("seqE_fire_top");
        @(negedge clk);
        compare_model();
        chk("seqE_wrap_addr", imem_addr, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Randomized traffic: random grant, latency, stall, flush, redirect.
        do_reset();
        rand_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            s = ($urandom_range(0, 9) < 3);
            f = ($urandom_range(0, 19) == 0);
            p = ($urandom_range(0, 19) == 0);
            t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : ($urandom & 32'h0000_0FFF);
            cyc(s, f, p, t);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
